// File: rtl/mc_readout_pkg.sv
// Shared types and helpers for the register readout serializer.
// State encoding is a plain 2-bit vector so it can be inspected on legacy probes.
package mc_readout_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_START = 2'd1;
  localparam state_t ST_DATA  = 2'd2;
  localparam state_t ST_STOP  = 2'd3;

  // Cycles from the first start-bit cycle to the last stop-bit cycle.
  function automatic int unsigned frame_cycles(input int unsigned width,
                                               input int unsigned bit_ticks);
    return (width + 2) * bit_ticks;
  endfunction

endpackage

// File: rtl/mc_tick_counter.sv
// Bit-period prescaler: WRAP marks the last cycle of each serial bit while enabled.
// Holds at zero whenever EN is low so every frame starts on a fresh bit period.
module mc_tick_counter #(
  parameter int BIT_TICKS = 4
) (
  input  logic CLK,
  input  logic ARST_N,
  input  logic EN,
  output logic WRAP
);

  localparam int CW = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
  localparam logic [CW-1:0] LAST_TICK = CW'(BIT_TICKS - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!EN || (cnt_q == LAST_TICK)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign WRAP = EN && (cnt_q == LAST_TICK);

endmodule

// File: rtl/mc_reg_readout.sv
// Snapshot a register value and shift it out as a framed one-wire stream:
// start bit (0), data LSB first, stop bit (1), each bit held BIT_TICKS cycles.
module mc_reg_readout
  import mc_readout_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int BIT_TICKS = 4
) (
  input  logic             CLK,
  input  logic             ARST_N,
  input  logic             SNAP_VALID,
  input  logic [WIDTH-1:0] SNAP_DATA,
  output logic             SNAP_READY,
  output logic             TX,
  output logic             BUSY,
  output logic             DONE
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST_BIT = IW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [IW-1:0]    bit_idx_q, bit_idx_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tick_en;
  logic             bit_wrap;

  assign tick_en = (state_q != ST_IDLE);

  mc_tick_counter #(
    .BIT_TICKS(BIT_TICKS)
  ) u_tick (
    .CLK   (CLK),
    .ARST_N(ARST_N),
    .EN    (tick_en),
    .WRAP  (bit_wrap)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (SNAP_VALID && SNAP_READY) begin
          state_d = ST_START;
          shift_d = SNAP_DATA;
        end
      end
      ST_START: begin
        if (bit_wrap) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (bit_wrap) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == LAST_BIT) begin
            bit_idx_d = '0;
            state_d   = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + IW'(1);
          end
        end
      end
      ST_STOP: begin
        if (bit_wrap) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state they describe.
  always_comb begin
    busy_d = (state_d != ST_IDLE);
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign SNAP_READY = (state_q == ST_IDLE);
  assign TX         = tx_q;
  assign BUSY       = busy_q;
  assign DONE       = done_q;

endmodule

// File: tb/tb_mc_reg_readout.sv
// Scoreboarded bench for mc_reg_readout: an 8-bit/4-tick instance and a 1-bit/1-tick instance.
// Expected TX waveforms come from the framing rules; monitors compare on each DONE.
module tb_mc_reg_readout;
  import mc_readout_pkg::*;

  localparam int W   = 8;
  localparam int BT  = 4;
  localparam int FR  = int'(frame_cycles(W, BT));
  localparam int W1  = 1;
  localparam int BT1 = 1;
  localparam int FR1 = int'(frame_cycles(W1, BT1));

  typedef struct {
    logic [7:0] data;
    int         acc;
  } exp_t;

  logic       clk = 1'b0;
  logic       arst_n = 1'b0;
  logic       a_valid = 1'b0;
  logic [7:0] a_data = 8'h00;
  logic       a_ready, a_tx, a_busy, a_done;
  logic       b_valid = 1'b0;
  logic [0:0] b_data = 1'b0;
  logic       b_ready, b_tx, b_busy, b_done;

  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  int   last_acc_a = 0;
  int   last_acc_b = 0;
  exp_t qa[$];
  exp_t qb[$];
  logic a_cap[$];
  logic b_cap[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mc_reg_readout #(.WIDTH(W), .BIT_TICKS(BT)) dut_a (
    .CLK(clk), .ARST_N(arst_n), .SNAP_VALID(a_valid), .SNAP_DATA(a_data),
    .SNAP_READY(a_ready), .TX(a_tx), .BUSY(a_busy), .DONE(a_done)
  );

  mc_reg_readout #(.WIDTH(W1), .BIT_TICKS(BT1)) dut_b (
    .CLK(clk), .ARST_N(arst_n), .SNAP_VALID(b_valid), .SNAP_DATA(b_data),
    .SNAP_READY(b_ready), .TX(b_tx), .BUSY(b_busy), .DONE(b_done)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Line level during cycle c of a frame (c = 0 is the first start-bit cycle).
  function automatic logic ref_bit(input logic [7:0] d, input int w, input int bt, input int c);
    int slot;
    slot = c / bt;
    if (slot == 0) return 1'b0;
    if (slot <= w) return d[slot-1];
    return 1'b1;
  endfunction

  // ---------------- monitors ----------------
  exp_t        ea, eb;
  logic [63:0] a_got, a_exp, b_got, b_exp;

  always @(negedge clk) begin
    if (!arst_n) begin
      a_cap.delete();
    end else begin
      if (a_busy) a_cap.push_back(a_tx);
      else check("a_idle_tx", 64'(a_tx), 64'd1);
      if (a_done) begin
        check("a_done_ready", 64'(a_ready), 64'd1);
        if (qa.size() == 0) begin
          check("a_spurious_done", 64'd1, 64'd0);
        end else begin
          ea = qa.pop_front();
          a_got = '0;
          a_exp = '0;
          foreach (a_cap[i]) if (i < 64) a_got[i] = a_cap[i];
          for (int c = 0; c < FR; c++) a_exp[c] = ref_bit(ea.data, W, BT, c);
          check("a_frame_len", 64'(a_cap.size()), 64'(FR));
          check("a_frame_bits", a_got, a_exp);
          check("a_done_latency", 64'(cyc - ea.acc), 64'(FR + 1));
          $display("A frame data=0x%02h accept_cyc=%0d done_cyc=%0d", ea.data, ea.acc, cyc);
        end
        a_cap.delete();
      end
    end
  end

  always @(negedge clk) begin
    if (!arst_n) begin
      b_cap.delete();
    end else begin
      if (b_busy) b_cap.push_back(b_tx);
      else check("b_idle_tx", 64'(b_tx), 64'd1);
      if (b_done) begin
        check("b_done_ready", 64'(b_ready), 64'd1);
        if (qb.size() == 0) begin
          check("b_spurious_done", 64'd1, 64'd0);
        end else begin
          eb = qb.pop_front();
          b_got = '0;
          b_exp = '0;
          foreach (b_cap[i]) if (i < 64) b_got[i] = b_cap[i];
          for (int c = 0; c < FR1; c++) b_exp[c] = ref_bit(eb.data, W1, BT1, c);
          check("b_frame_len", 64'(b_cap.size()), 64'(FR1));
          check("b_frame_bits", b_got, b_exp);
          check("b_done_latency", 64'(cyc - eb.acc), 64'(FR1 + 1));
          $display("B frame data=%0d accept_cyc=%0d done_cyc=%0d", eb.data[0], eb.acc, cyc);
        end
        b_cap.delete();
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_a(input logic [7:0] d, input bit keep);
    int n;
    n = 0;
    @(negedge clk);
    a_valid = 1'b1;
    a_data  = d;
    while (!a_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!a_ready) begin
      check("a_accept_timeout", 64'd0, 64'd1);
      a_valid = 1'b0;
      return;
    end
    qa.push_back('{data: d, acc: cyc});
    last_acc_a = cyc;
    @(posedge clk);
    #1;
    if (!keep) a_valid = 1'b0;
  endtask

  task automatic send_b(input logic d, input bit keep);
    int n;
    n = 0;
    @(negedge clk);
    b_valid = 1'b1;
    b_data  = d;
    while (!b_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!b_ready) begin
      check("b_accept_timeout", 64'd0, 64'd1);
      b_valid = 1'b0;
      return;
    end
    qb.push_back('{data: {7'd0, d}, acc: cyc});
    last_acc_b = cyc;
    @(posedge clk);
    #1;
    if (!keep) b_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((a_busy || b_busy) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 64'(a_busy || b_busy), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int acc1;
    logic [7:0] d;

    // Reset state on both instances.
    @(negedge clk);
    check("rst_a_tx", 64'(a_tx), 64'd1);
    check("rst_a_busy", 64'(a_busy), 64'd0);
    check("rst_a_done", 64'(a_done), 64'd0);
    check("rst_a_ready", 64'(a_ready), 64'd1);
    check("rst_b_tx", 64'(b_tx), 64'd1);
    check("rst_b_ready", 64'(b_ready), 64'd1);
    repeat (2) @(negedge clk);
    arst_n = 1'b1;

    // Idle line after reset.
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("idle_tx", 64'(a_tx), 64'd1);
      check("idle_busy", 64'(a_busy), 64'd0);
      check("idle_done", 64'(a_done), 64'd0);
    end

    // Single frame 0xA5.
    send_a(8'hA5, 1'b0);
    wait_idle();

    // Back-to-back with SNAP_VALID held: second accept lands in the DONE cycle.
    send_a(8'h00, 1'b1);
    acc1 = last_acc_a;
    send_a(8'hFF, 1'b0);
    check("b2b_accept_period", 64'(last_acc_a - acc1), 64'(FR + 1));
    wait_idle();

    // Input changes and valid pulses mid-frame are ignored.
    send_a(8'h3C, 1'b0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      a_data  = 8'hC3;
      a_valid = 1'($urandom_range(0, 1));
      check("midframe_ready", 64'(a_ready), 64'd0);
    end
    a_valid = 1'b0;
    wait_idle();

    // Asynchronous reset during data bit 3.
    d = 8'($urandom);
    send_a(d, 1'b0);
    while (cyc < last_acc_a + 4 * BT + 2) @(negedge clk);
    check("pre_rst_busy", 64'(a_busy), 64'd1);
    #1;
    arst_n = 1'b0;
    #1;
    check("arst_tx", 64'(a_tx), 64'd1);
    check("arst_busy", 64'(a_busy), 64'd0);
    check("arst_ready", 64'(a_ready), 64'd1);
    check("arst_done", 64'(a_done), 64'd0);
    void'(qa.pop_back());
    $display("A frame data=0x%02h abandoned by reset at cycle %0d", d, cyc);
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_tx", 64'(a_tx), 64'd1);
    send_a(8'h96, 1'b0);
    wait_idle();

    // Randomized frames with random gaps, some back-to-back.
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send_a(8'($urandom), 1'($urandom_range(0, 2) == 0));
    end
    a_valid = 1'b0;
    wait_idle();

    // Minimal instance: one data bit, one cycle per bit.
    send_b(1'b1, 1'b0);
    wait_idle();
    send_b(1'b0, 1'b1);
    acc1 = last_acc_b;
    send_b(1'b1, 1'b0);
    check("b_b2b_accept_period", 64'(last_acc_b - acc1), 64'(FR1 + 1));
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send_b(1'($urandom), 1'($urandom_range(0, 1)));
    end
    b_valid = 1'b0;
    wait_idle();

    check("a_queue_empty", 64'(qa.size()), 64'd0);
    check("b_queue_empty", 64'(qb.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, passed %0d of %0d", passes, checks);
    $fatal(1);
  end

endmodule

// File: doc/mc_reg_readout.md
# mc_reg_readout

Parallel-in, serial-out readout block. It snapshots a WIDTH-bit register value and shifts it out as a framed one-wire serial stream: start bit, data LSB first, stop bit. It is the read side of the design's flip-flop state: it takes register contents and drives a slow redstone display or probe line. Every piece of state is in registers that map onto the async-reset flip-flop primitive.

## Interface
- WIDTH, 8, data bits per frame; must be at least 1.
- BIT_TICKS, 4, CLK cycles each serial bit is held; must be at least 1.
- CLK  in  1  clock, positive-edge.
- ARST_N  in  1  reset, asynchronous, active-low.
- SNAP_VALID  in  1  snapshot request; held until accepted.
- SNAP_DATA  in  WIDTH  value to serialize; sampled only on accept.
- SNAP_READY  out  1  block can accept a snapshot.
- TX  out  1  serial line; idles high.
- BUSY  out  1  a frame is in progress.
- DONE  out  1  one-cycle pulse when a frame completes.

## Operation
- States:
  - IDLE → START: when SNAP_VALID && SNAP_READY on a rising edge (the "accept"). SNAP_DATA is latched into the shift register at that edge.
  - START → DATA: after BIT_TICKS cycles.
  - DATA → STOP: after WIDTH bits, each held BIT_TICKS cycles.
  - STOP → IDLE: after BIT_TICKS cycles.
- TX per state: IDLE 1; START 0; DATA is shift-register bit 0 (LSB first); STOP 1.
- Shifting: the shift register shifts right once per completed data bit. The bit index counts 0..WIDTH-1.
- SNAP_READY is 1 only in IDLE, and is combinational from the state register.
- BUSY is 1 in START, DATA and STOP.
- DONE is 1 for exactly the first IDLE cycle after STOP.
- Input sampling: SNAP_DATA and SNAP_VALID are ignored outside IDLE. Changing SNAP_DATA after accept does not affect the frame.
- Back-to-back frames: DONE and SNAP_READY are both 1 in the same cycle. A request pending in that cycle is accepted, so frames are separated by exactly one idle-high TX cycle.
- Reset (ARST_N=0): asynchronously forces state IDLE, TX=1, SNAP_READY=1, BUSY=0, DONE=0, tick counter 0, bit index 0, shift register 0.
- Reset mid-frame: the frame is abandoned immediately and TX returns high. After ARST_N deasserts there is no partial resend.
- Widths and wrap-around:
  - Tick counter is max(1,$clog2(BIT_TICKS)) bits wide. It counts 0..BIT_TICKS-1 and clears on wrap.
  - Bit index is max(1,$clog2(WIDTH)) bits wide.
  - No counter overflows for any legal parameter value.
- BIT_TICKS=1: every bit lasts one cycle. The tick counter stays at 0 and every cycle is a bit boundary.

## Timing
- Accept at edge N. START drives TX=0 during cycles N+1 .. N+BIT_TICKS.
- Data bit k occupies cycles N+1+(k+1)·BIT_TICKS .. N+(k+2)·BIT_TICKS.
- Stop bit ends at cycle N+(WIDTH+2)·BIT_TICKS.
- DONE=1 in cycle N+(WIDTH+2)·BIT_TICKS+1.
- Frame length is (WIDTH+2)·BIT_TICKS cycles. Minimum accept-to-accept period is (WIDTH+2)·BIT_TICKS+1 cycles.
- TX, BUSY and DONE are registered outputs with no combinational path from inputs. SNAP_READY is decoded from the state register only.

## Structure
- Package mc_readout_pkg contains:
  - state typedef: IDLE, START, DATA, STOP (2-bit encoding);
  - function frame_cycles(WIDTH, BIT_TICKS) returning (WIDTH+2)·BIT_TICKS, shared by RTL assertions and the bench.
- Sub-module mc_tick_counter(CLK, ARST_N, EN, WRAP):
  - BIT_TICKS prescaler with async active-low reset.
  - WRAP pulses on the last tick of each bit.
  - Instantiated once.
- Top level holds the FSM, the shift register and the bit index.

## Test plan
- Single frame: WIDTH=8, BIT_TICKS=4, send 0xA5 → TX holds 0,1,0,1,0,0,1,0,1,1 for 4 cycles each; DONE pulses at accept+41; BUSY high for 40 cycles.
- Back-to-back: SNAP_VALID held with 0x00 then 0xFF → second accept occurs in the DONE cycle; exactly 1 idle-high cycle between stop bit and next start bit.
- Data stability: accept 0x3C, then change SNAP_DATA to 0xC3 and pulse SNAP_VALID mid-frame → transmitted bits are 0x3C; no extra accept; SNAP_READY stays 0 until DONE.
- Reset mid-frame: assert ARST_N low during data bit 3 → TX=1, BUSY=0, SNAP_READY=1 within the same cycle (asynchronous); after release, the next accept produces a full clean frame.
- BIT_TICKS=1, WIDTH=1: send 1 → TX sequence 0,1,1 on consecutive cycles; DONE at accept+4.
- Idle: SNAP_VALID=0 for 100 cycles after reset → TX=1, BUSY=0, DONE=0 throughout.
